// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble insertion, flush/stall priority and WB->ID write-through bypass.
// Optional hazard counters are enabled by defining HAZARD_PERF_EN.
module id_ex_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic                  id_alu_src,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_reg_write,
   input  logic                  id_mem_to_reg,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  flush_ex,
   input  logic                  stall_mem,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_pc,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]       ex_rs1_data,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [XLEN-1:0]       ex_imm,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic                  ex_alu_src,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_reg_write,
   output logic                  ex_mem_to_reg,
   output logic                  stall_if_id
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           perf_lu_cnt,
   output logic [31:0]           perf_flush_cnt,
   output logic [31:0]           perf_stall_cnt
`endif
);

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       pc;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic [ALU_OP_W-1:0]   alu_op;
      logic                  alu_src;
      logic                  mem_read;
      logic                  mem_write;
      logic                  reg_write;
      logic                  mem_to_reg;
   } ex_t;

   ex_t  ex_q, ex_d;
   logic lu, byp_rs1, byp_rs2;

   assign lu = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
               ((id_uses_rs1 && (id_rs1 == ex_q.rd)) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));

   // The register file writes at the end of this cycle, so ID read stale data.
   assign byp_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
   assign byp_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

   assign stall_if_id = !rst && (stall_mem || (!flush_ex && lu));

   always_comb begin
      ex_d = ex_q;
      if (stall_mem) begin
         ex_d = ex_q;
      end else if (flush_ex || lu) begin
         ex_d = '0;
      end else begin
         ex_d.valid      = id_valid;
         ex_d.pc         = id_pc;
         ex_d.rs1        = id_rs1;
         ex_d.rs2        = id_rs2;
         ex_d.rd         = id_rd;
         ex_d.rs1_data   = byp_rs1 ? wb_data : id_rs1_data;
         ex_d.rs2_data   = byp_rs2 ? wb_data : id_rs2_data;
         ex_d.imm        = id_imm;
         ex_d.alu_op     = id_alu_op;
         ex_d.alu_src    = id_alu_src;
         ex_d.mem_read   = id_mem_read   && id_valid;
         ex_d.mem_write  = id_mem_write  && id_valid;
         ex_d.reg_write  = id_reg_write  && id_valid;
         ex_d.mem_to_reg = id_mem_to_reg && id_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign ex_valid      = ex_q.valid;
   assign ex_pc         = ex_q.pc;
   assign ex_rs1        = ex_q.rs1;
   assign ex_rs2        = ex_q.rs2;
   assign ex_rd         = ex_q.rd;
   assign ex_rs1_data   = ex_q.rs1_data;
   assign ex_rs2_data   = ex_q.rs2_data;
   assign ex_imm        = ex_q.imm;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;

`ifdef HAZARD_PERF_EN
   logic [31:0] lu_cnt_q, flush_cnt_q, stall_cnt_q;

   // Only the winning case of the priority chain is counted each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_cnt_q    <= '0;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (stall_mem) begin
         if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      end else if (flush_ex) begin
         if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
      end else if (lu) begin
         if (lu_cnt_q != '1) lu_cnt_q <= lu_cnt_q + 32'd1;
      end
   end

   assign perf_lu_cnt    = lu_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
